// File: rtl/kudu_dv_pkg.sv
// kudu_dv_pkg: shared channel-state enum, LFSR taps and delay helpers for the interrupt generator.
package kudu_dv_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ASSERT, HOLD} intr_st_e;
  localparam logic [15:0] LfsrTaps = 16'hB400;
  function automatic logic [16:0] calc_delay(input logic [15:0] rnd, input logic [3:0] intvl);
    logic [16:0] base;
    base = 17'd1 << intvl;
    return base + ({1'b0, rnd} & (base - 17'd1));
  endfunction
  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned s);
    logic [31:0] w;
    w = {v, v} << s;
    return w[31:16];
  endfunction
endpackage

// File: rtl/intr_gen_mc_chan.sv
// intr_chan: one interrupt channel -- delay FSM, ack timeout, spurious-ack flag and fire counter.
module intr_chan import kudu_dv_pkg::*; #(
  parameter int CntW       = 16,
  parameter int HoldOff    = 4,
  parameter int AckTimeout = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      intvl,
  input  logic            pulse,
  input  logic            ack,
  input  logic [15:0]     rnd,
  output logic            irq,
  output logic            to_err,
  output logic            spur_err,
  output logic [CntW-1:0] fire
);
  localparam int TW = $clog2(AckTimeout + 1);
  localparam logic [16:0] DMax = 17'((64'd1 << (CntW >= 17 ? 17 : CntW)) - 64'd1);
  intr_st_e st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d, fire_q, fire_d, load;
  logic [TW-1:0] tmr_q, tmr_d;
  logic pulse_q, pulse_d, irq_q, irq_d, to_err_q, to_err_d, spur_q, spur_d, arm, tmr_end;
  logic [16:0] dly;
  always_comb begin
    dly = calc_delay(rnd, intvl);
    load = CntW'((dly > DMax ? DMax : dly) - 17'd1);
    arm = en && intvl != 4'd0;
    tmr_end = tmr_q == TW'(AckTimeout - 1);
    st_d = st_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    pulse_d = pulse_q;
    to_err_d = to_err_q;
    fire_d = fire_q;
    spur_d = spur_q | (ack && !(st_q == ASSERT && !pulse_q));
    case (st_q)
      IDLE: if (arm) begin
        st_d = WAIT;
        cnt_d = load;
      end
      WAIT: if (!arm) st_d = IDLE;
      else if (cnt_q == '0) begin
        st_d = ASSERT;
        pulse_d = pulse;
        tmr_d = '0;
        fire_d = fire_q + CntW'(fire_q != '1);
      end else cnt_d = cnt_q - 1'b1;
      ASSERT: if (pulse_q || ack) begin
        st_d = HOLD;
        cnt_d = CntW'(HoldOff - 1);
      end else begin
        tmr_d = tmr_q + TW'(!tmr_end);
        to_err_d = to_err_q | tmr_end;
      end
      // The final HOLD cycle doubles as the IDLE re-arm decision, so HoldOff idle cycles precede WAIT.
      HOLD: if (cnt_q == '0) begin
        st_d = arm ? WAIT : IDLE;
        cnt_d = load;
      end else cnt_d = cnt_q - 1'b1;
    endcase
    irq_d = st_d == ASSERT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      tmr_q <= '0;
      pulse_q <= 1'b0;
      irq_q <= 1'b0;
      to_err_q <= 1'b0;
      spur_q <= 1'b0;
      fire_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      pulse_q <= pulse_d;
      irq_q <= irq_d;
      to_err_q <= to_err_d;
      spur_q <= spur_d;
      fire_q <= fire_d;
    end
  assign irq = irq_q;
  assign to_err = to_err_q;
  assign spur_err = spur_q;
  assign fire = fire_q;
endmodule

// File: rtl/intr_gen_mc.sv
// intr_gen_mc: multi-channel interrupt generator; one shared Galois LFSR feeds NumIrq independent channels.
module intr_gen_mc import kudu_dv_pkg::*; #(
  parameter int          NumIrq     = 3,
  parameter int          CntW       = 16,
  parameter logic [15:0] LfsrSeed   = 16'hACE1,
  parameter int          HoldOff    = 4,
  parameter int          AckTimeout = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   intr_en,
  input  logic [4*NumIrq-1:0]    cfg_intvl,
  input  logic [NumIrq-1:0]      cfg_pulse,
  input  logic [NumIrq-1:0]      intr_ack,
  output logic [NumIrq-1:0]      irq_o,
  output logic [NumIrq-1:0]      ack_to_err,
  output logic [NumIrq-1:0]      spur_ack_err,
  output logic [CntW*NumIrq-1:0] fire_cnt
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= LfsrSeed;
    else lfsr_q <= lfsr_d;
  for (genvar i = 0; i < NumIrq; i++) begin : g_ch
    intr_chan #(.CntW(CntW), .HoldOff(HoldOff), .AckTimeout(AckTimeout)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (intr_en),
      .intvl    (cfg_intvl[4*i +: 4]),
      .pulse    (cfg_pulse[i]),
      .ack      (intr_ack[i]),
      .rnd      (rotl16(lfsr_q, (5 * i) % 16)),
      .irq      (irq_o[i]),
      .to_err   (ack_to_err[i]),
      .spur_err (spur_ack_err[i]),
      .fire     (fire_cnt[CntW*i +: CntW])
    );
  end
endmodule

// File: tb/tb_intr_gen_mc.sv
// tb_intr_gen_mc: directed self-checking bench for intr_gen_mc (3 channels, AckTimeout=16).
module tb_intr_gen_mc;
  localparam int HO = 4;
  localparam int AT = 16;
  logic clk = 1'b0, rst_n = 1'b0, intr_en = 1'b0;
  logic [11:0] cfg_intvl = '0;
  logic [2:0] cfg_pulse = '0, intr_ack = '0;
  logic [2:0] irq_o, ack_to_err, spur_ack_err;
  logic [47:0] fire_cnt;
  int n_chk = 0, n_err = 0;
  int hi[3], rises[3], last_fall[3];
  bit prev[3], fell[3];
  int t_err, lows, acc, last_rise, np, hi0, other;
  bit prev0;

  intr_gen_mc #(.AckTimeout(AT)) dut (
    .clk(clk), .rst_n(rst_n), .intr_en(intr_en), .cfg_intvl(cfg_intvl), .cfg_pulse(cfg_pulse),
    .intr_ack(intr_ack), .irq_o(irq_o), .ack_to_err(ack_to_err), .spur_ack_err(spur_ack_err),
    .fire_cnt(fire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    intr_en = 1'b0;
    intr_ack = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rise(input int c, input int lim);
    int k;
    k = 0;
    while (!irq_o[c] && k < lim) begin
      tick();
      k++;
    end
    chk($sformatf("rise_ch%0d", c), irq_o[c], 1);
  endtask

  function automatic logic [15:0] fc(input int c);
    return fire_cnt[16*c +: 16];
  endfunction

  initial begin
    // reset values and LFSR stepping
    cfg_intvl = 12'h111;
    repeat (3) tick();
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    chk("rst_irq", irq_o, 0);
    chk("rst_fire", fire_cnt, 0);
    chk("rst_err", {ack_to_err, spur_ack_err}, 0);
    rst_n = 1'b1;
    tick();
    chk("lfsr_step1", dut.lfsr_q, 16'hE270);
    tick();
    chk("lfsr_step2", dut.lfsr_q, 16'h7138);
    acc = 0;
    repeat (100) begin
      tick();
      acc += int'(irq_o != 0);
    end
    chk("dis_irq", acc, 0);
    chk("dis_fire", fire_cnt, 0);

    // level mode on all channels, ack after three high cycles
    do_reset();
    cfg_intvl = 12'h111;
    cfg_pulse = '0;
    intr_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hi[c] = 0; rises[c] = 0; last_fall[c] = 0; prev[c] = 0; fell[c] = 0;
    end
    for (int t = 0; t < 300; t++) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        if (irq_o[c] && !prev[c]) begin
          rises[c]++;
          if (fell[c])
            chk($sformatf("gap_ch%0d_len%0d", c, t - last_fall[c]), (t - last_fall[c]) inside {[HO+2:HO+3]}, 1);
        end
        if (!irq_o[c] && prev[c]) begin
          fell[c] = 1;
          last_fall[c] = t;
        end
        hi[c] = irq_o[c] ? hi[c] + 1 : 0;
        prev[c] = irq_o[c];
        intr_ack[c] = hi[c] == 3;
      end
    end
    intr_ack = '0;
    chk("lvl_to_err", ack_to_err, 0);
    chk("lvl_spur", spur_ack_err, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("lvl_fire_ch%0d", c), fc(c), 16'(rises[c]));
      chk($sformatf("lvl_rises_ch%0d_n%0d", c, rises[c]), rises[c] >= 15, 1);
    end

    // pulse mode on channel 0
    do_reset();
    cfg_intvl = 12'h002;
    cfg_pulse = 3'b001;
    intr_en = 1'b1;
    prev0 = 0; last_rise = -1; np = 0; hi0 = 0; other = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (irq_o[0] && !prev0) begin
        if (last_rise >= 0)
          chk($sformatf("pulse_period_%0d", t - last_rise), (t - last_rise) inside {[HO+5:HO+8]}, 1);
        last_rise = t;
        np++;
      end
      if (!irq_o[0] && prev0) chk("pulse_width", hi0, 1);
      hi0 = irq_o[0] ? hi0 + 1 : 0;
      prev0 = irq_o[0];
      other += int'(irq_o[2:1] != 0);
    end
    chk("pulse_spur", spur_ack_err, 0);
    chk("pulse_other", other, 0);
    chk($sformatf("pulse_count_%0d", np), np >= 10, 1);
    chk("pulse_fire", fc(0), 16'(np));

    // level mode never acked -> timeout
    do_reset();
    cfg_intvl = 12'h001;
    cfg_pulse = '0;
    intr_en = 1'b1;
    wait_rise(0, 20);
    t_err = -1; lows = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ack_to_err[0] && t_err < 0) t_err = k;
      lows += int'(!irq_o[0]);
    end
    chk("to_latency", t_err, 16);
    chk("to_irq_held", lows, 0);
    chk("to_fire", fc(0), 1);
    chk("to_err_vec", ack_to_err, 3'b001);
    chk("to_spur", spur_ack_err, 0);

    // intr_en dropped in WAIT and in level ASSERT on channel 1
    do_reset();
    cfg_intvl = 12'h040;
    cfg_pulse = '0;
    intr_en = 1'b1;
    repeat (5) tick();
    intr_en = 1'b0;
    acc = 0;
    repeat (60) begin
      tick();
      acc += int'(irq_o[1]);
    end
    chk("wait_drop_irq", acc, 0);
    chk("wait_drop_fire", fc(1), 0);
    intr_en = 1'b1;
    wait_rise(1, 50);
    intr_en = 1'b0;
    acc = 0;
    repeat (10) begin
      tick();
      acc += int'(irq_o[1]);
    end
    chk("en_drop_held", acc, 10);
    intr_ack = 3'b010;
    tick();
    intr_ack = '0;
    chk("ack_fall", irq_o[1], 0);
    chk("ack_spur", spur_ack_err, 0);
    chk("ack_to_err", ack_to_err, 0);
    repeat (40) tick();
    chk("no_refire", fc(1), 1);
    chk("no_refire_irq", irq_o, 0);

    // spurious acks on channel 2 and async reset mid-ASSERT
    do_reset();
    intr_ack = 3'b100;
    tick();
    intr_ack = '0;
    chk("spur_idle", spur_ack_err, 3'b100);
    repeat (10) tick();
    chk("spur_sticky", spur_ack_err, 3'b100);
    do_reset();
    chk("spur_rst", spur_ack_err, 0);
    cfg_intvl = 12'h100;
    cfg_pulse = 3'b100;
    intr_en = 1'b1;
    wait_rise(2, 20);
    intr_ack = 3'b100;
    tick();
    intr_ack = '0;
    chk("spur_pulse", spur_ack_err, 3'b100);
    chk("pulse_one_cycle", irq_o[2], 0);
    cfg_pulse = '0;
    wait_rise(2, 20);
    repeat (3) tick();
    chk("lvl_held_ch2", irq_o[2], 1);
    chk("spur_kept", spur_ack_err, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", irq_o, 0);
    chk("async_spur", spur_ack_err, 0);
    chk("async_fire", fire_cnt, 0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/intr_gen_mc.md
Name: intr_gen_mc

Overview:
- Multi-channel, parametrised successor to the single-vector testbench interrupt generator.
- Drives NumIrq independent interrupt lines into the core under test (timer/software/external, plus fast IRQs).
- Each channel has a per-channel interval, a level or pulse mode, and an ack handshake fed back from the data memory model's interrupt-ack register.
- Adds ack-timeout and spurious-ack checking, and per-channel fire counters for coverage.

Parameters:
- NumIrq, 3, number of interrupt channels (1..16).
- CntW, 16, width of the delay counter and of the fire counters.
- LfsrSeed, 16'hACE1, reset value of the shared 16-bit LFSR; must be nonzero.
- HoldOff, 4, idle cycles after a channel completes before it re-arms (>=1).
- AckTimeout, 1024, maximum cycles a level IRQ may stay asserted before ack_to_err is flagged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- intr_en  in  1  global enable.
- cfg_intvl  in  4*NumIrq  per-channel interval exponent; channel i uses bits [4i+3:4i]; 0 disables the channel.
- cfg_pulse  in  NumIrq  per-channel mode: 1 = single-cycle pulse, 0 = level held until ack.
- intr_ack  in  NumIrq  per-channel acknowledge, sampled each cycle.
- irq_o  out  NumIrq  interrupt lines.
- ack_to_err  out  NumIrq  sticky: level IRQ not acked within AckTimeout cycles.
- spur_ack_err  out  NumIrq  sticky: ack seen while the channel is not in ASSERT.
- fire_cnt  out  CntW*NumIrq  per-channel count of IRQ assertions; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, every channel in IDLE, LFSR = LfsrSeed. All registers are asynchronously reset.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle after reset, regardless of intr_en.
  - Channel i draws rnd_i = LFSR rotated left by (5*i mod 16).
- Delay for intvl n (1..15): D = (1<<n) + (rnd_i & ((1<<n)-1)), so D is in [2^n, 2^(n+1)-1]. For n=15, D is computed in 17 bits and clamped to all-ones of CntW.
- Per-channel FSM (states IDLE, WAIT, ASSERT, HOLD):
  - IDLE: if intr_en=1 and intvl!=0, load cnt=D-1 and go to WAIT. Otherwise stay in IDLE.
  - WAIT: if intr_en=0 or intvl==0, go to IDLE (no irq). Else if cnt==0, go to ASSERT. Else decrement cnt.
  - ASSERT: irq_o[i]=1, registered, so it rises the cycle after WAIT ends. fire_cnt[i] increments on entry.
    - Pulse mode: exactly one cycle high, then HOLD. Ack is not required.
    - Level mode: held until intr_ack[i]=1. irq_o drops the cycle after ack is sampled, then HOLD. intr_en=0 does not drop a level IRQ.
    - A timer counts ASSERT cycles. When it reaches AckTimeout, ack_to_err[i] is set and irq stays asserted.
  - HOLD: load cnt=HoldOff-1 and count down, then IDLE.
- The mode is sampled on ASSERT entry. A cfg_pulse change while in ASSERT has no effect until the next assertion.
- Spurious ack: intr_ack[i]=1 in any state other than level-mode ASSERT sets spur_ack_err[i]. This includes ack in pulse mode and ack in the same cycle as ASSERT entry.
- The sticky errors clear only on reset.
- Channels are fully independent. Simultaneous assertions on several channels are legal.
- Reset mid-ASSERT drops irq_o asynchronously.

Decomposition:
- Shared tb package (kudu_dv_pkg) holds:
  - the channel-state enum intr_st_e {IDLE, WAIT, ASSERT, HOLD};
  - the LFSR tap constant;
  - the function calc_delay(rnd, intvl).
- One sub-module, intr_chan, holds a single channel's FSM, counters, error flags and fire counter.
- intr_gen_mc contains the LFSR plus a generate loop instantiating NumIrq copies of intr_chan.

Test Plan:
- Reset, intr_en=0, 100 cycles -> irq_o=0, fire_cnt=0, LFSR=16'hACE1 during reset.
- NumIrq=3, cfg_intvl=12'h111, cfg_pulse=0, ack 3 cycles after each rise:
  - every gap between fall and next rise is in [HoldOff+2, HoldOff+3] cycles;
  - no errors;
  - fire_cnt matches the rise count.
- Channel 0 pulse mode, intvl=2, intr_en=1 for 200 cycles -> each irq_o[0] high exactly 1 cycle, period in [4+4+1, 7+4+1] cycles, spur_ack_err=0.
- Level mode, intvl=1, never ack; AckTimeout=16 for this test -> irq stays high, ack_to_err[0] set exactly 16 cycles after rise, fire_cnt[0]=1.
- intr_en dropped while channel 1 is in WAIT, and while in level ASSERT:
  - WAIT returns to IDLE with no IRQ;
  - the asserted line stays high until ack.
- Ack on channel 2 while in IDLE, and while in pulse mode -> spur_ack_err[2]=1, stays set until rst_n=0; async reset mid-ASSERT clears irq_o before the next clk edge.
